// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_master among NREQ requesters.
// Grants one request at a time, holds new_data for the master's slow FSM,
// then waits for the slave done rise (or a timeout) and returns an ack pulse.
module spi_txn_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 12,
  parameter int LAUNCH_CYC = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     spi_new_data,
  output logic [DW-1:0]            spi_din,
  input  logic                     spi_done
);

  localparam int IW = $clog2(NREQ);
  localparam int LW = (LAUNCH_CYC > 1) ? $clog2(LAUNCH_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COMPLETE
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [LW-1:0]   lcnt;
  logic [TW-1:0]   tcnt;
  logic            d1;
  logic            d2;

  logic [DW-1:0]   words [NREQ];
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            any_req;

  // Round-robin pick: first requester found searching upward from last+1.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      words[i] = req_data[i*DW +: DW];
    end
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(last) + i) % NREQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // Transaction FSM with registered outputs and done edge detector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      gnt          <= '0;
      ack          <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      owner        <= '0;
      last         <= IW'(NREQ - 1);
      spi_new_data <= 1'b0;
      spi_din      <= '0;
      lcnt         <= '0;
      tcnt         <= '0;
      d1           <= 1'b0;
      d2           <= 1'b0;
    end else begin
      d1  <= spi_done;
      d2  <= d1;
      gnt <= '0;
      ack <= '0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt[win]     <= 1'b1;
            owner        <= win;
            spi_din      <= words[win];
            spi_new_data <= 1'b1;
            busy         <= 1'b1;
            lcnt         <= '0;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (lcnt == LW'(LAUNCH_CYC - 1)) begin
            spi_new_data <= 1'b0;
            tcnt         <= '0;
            // Equalise the edge pair so a done already high here is not a rise.
            d2           <= spi_done;
            state        <= S_WAIT;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (d1 && !d2) begin
            ack[owner] <= 1'b1;
            err        <= 1'b0;
            state      <= S_COMPLETE;
          end else if (tcnt == TW'(TIMEOUT)) begin
            // WAIT spans TIMEOUT+1 cycles: error ack lands LAUNCH_CYC+TIMEOUT+1 after gnt.
            ack[owner] <= 1'b1;
            err        <= 1'b1;
            state      <= S_COMPLETE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_COMPLETE: begin
          last  <= owner;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
